// File: rtl/car_lane_array.sv
// Multi-lane Frogger obstacle generator: one car per lane, each moving at a
// speed set by the level, with all movement paced by an internal tick divider.
module car_lane_array #(
  parameter int            NUM_LANES  = 4,
  parameter int            TICK_DIV   = 15000000,
  parameter int            SCREEN_W   = 640,
  parameter int            CAR_W      = 60,
  parameter int            CAR_H      = 40,
  parameter int            LANE_TOP0  = 110,
  parameter int            LANE_PITCH = 60,
  parameter int            START_GAP  = 150,
  parameter int            SPEED0     = 10,
  parameter int            SPEED1     = 25,
  parameter int            SPEED2     = 40,
  parameter int            SPEED_STEP = 5,
  parameter logic [7:0]    DIR_MASK   = 8'b0000_1010
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    run,
  input  logic                    freeze,
  input  logic [2:0]              level,
  output logic [NUM_LANES*10-1:0] carL,
  output logic [NUM_LANES*10-1:0] carR,
  output logic [NUM_LANES*9-1:0]  carT,
  output logic [NUM_LANES*9-1:0]  carB,
  output logic                    tick,
  output logic [NUM_LANES-1:0]    wrap
);

  localparam int XMAX = SCREEN_W - CAR_W;
  localparam int CW   = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic [NUM_LANES-1:0]  wrap_q, wrap_d;
  logic [9:0]            posL_q [NUM_LANES];
  logic [9:0]            posL_d [NUM_LANES];
  logic [9:0]            posR_q [NUM_LANES];
  logic [9:0]            posR_d [NUM_LANES];
  logic [9:0]            baseSpd;

  // Right-to-left lanes mirror the stagger so they start from the far edge.
  function automatic logic [9:0] startPos(input int i);
    int off;
    off = (i * START_GAP) % (XMAX + 1);
    return DIR_MASK[i] ? 10'(XMAX - off) : 10'(off);
  endfunction

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        posL_q[i] <= startPos(i);
        posR_q[i] <= startPos(i) + 10'(CAR_W);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        posL_q[i] <= posL_d[i];
        posR_q[i] <= posR_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = IDLE; else if (freeze) state_d = PAUSE;
      PAUSE:   if (!run) state_d = IDLE; else if (!freeze) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (level)
      3'd0:    baseSpd = 10'(SPEED0);
      3'd1:    baseSpd = 10'(SPEED1);
      default: baseSpd = 10'(SPEED2);
    endcase
  end

  // The counter only advances while staying in RUN, so a freeze edge holds it.
  always_comb begin
    logic [10:0] n;
    logic [9:0]  spd;
    n      = '0;
    spd    = '0;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      posL_d[i] = posL_q[i];
      posR_d[i] = posR_q[i];
    end
    if (state_d == IDLE) begin
      cnt_d = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        posL_d[i] = startPos(i);
        posR_d[i] = startPos(i) + 10'(CAR_W);
      end
    end else if (state_q == RUN && state_d == RUN) begin
      if (cnt_q == CW'(TICK_DIV - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          spd = baseSpd + 10'(i * SPEED_STEP);
          if (DIR_MASK[i]) begin
            if (posL_q[i] < spd) begin
              posL_d[i] = 10'(XMAX);
              wrap_d[i] = 1'b1;
            end else begin
              posL_d[i] = posL_q[i] - spd;
            end
          end else begin
            n = {1'b0, posL_q[i]} + {1'b0, spd};
            if (n > 11'(XMAX)) begin
              posL_d[i] = '0;
              wrap_d[i] = 1'b1;
            end else begin
              posL_d[i] = n[9:0];
            end
          end
          posR_d[i] = posL_d[i] + 10'(CAR_W);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    assign carL[10*g +: 10] = posL_q[g];
    assign carR[10*g +: 10] = posR_q[g];
    assign carT[9*g +: 9]   = 9'(LANE_TOP0 + g * LANE_PITCH);
    assign carB[9*g +: 9]   = 9'(LANE_TOP0 + g * LANE_PITCH + CAR_H);
  end

endmodule

// File: tb/tb_car_lane_array.sv
// Directed bench for car_lane_array with a 4-cycle tick divider; expected
// positions are hand-computed from the lane speeds and start stagger.
module tb_car_lane_array;

  logic        clk_in;
  logic        reset_in;
  logic        run;
  logic        freeze;
  logic [2:0]  level;
  logic [39:0] carL;
  logic [39:0] carR;
  logic [35:0] carT;
  logic [35:0] carB;
  logic        tick;
  logic [3:0]  wrap;

  int errors = 0;
  int checks = 0;

  car_lane_array #(.TICK_DIV(4)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .run     (run),
    .freeze  (freeze),
    .level   (level),
    .carL    (carL),
    .carR    (carR),
    .carT    (carT),
    .carB    (carB),
    .tick    (tick),
    .wrap    (wrap)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [39:0] pk10(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Steps until tick is seen (bounded); reports cycles taken and any wrap off-tick.
  task automatic next_tick(output int cyc, output bit offWrap);
    cyc = 0;
    offWrap = 1'b0;
    do begin
      step();
      cyc++;
      if (!tick && wrap != 4'b0) offWrap = 1'b1;
    end while (!tick && cyc < 20);
  endtask

  task automatic test_reset();
    reset_in = 1'b0; run = 1'b0; freeze = 1'b0; level = 3'd0;
    step(); step();
    checks++;
    if (carL !== pk10(0, 430, 300, 130)) begin
      errors++; $display("[TB] FAIL reset_carL: got %h expected %h", carL, pk10(0, 430, 300, 130));
    end
    checks++;
    if (carR !== pk10(60, 490, 360, 190)) begin
      errors++; $display("[TB] FAIL reset_carR: got %h expected %h", carR, pk10(60, 490, 360, 190));
    end
    checks++;
    if (carT !== {9'd290, 9'd230, 9'd170, 9'd110}) begin
      errors++; $display("[TB] FAIL reset_carT: got %h expected %h", carT, {9'd290, 9'd230, 9'd170, 9'd110});
    end
    checks++;
    if (carB !== {9'd330, 9'd270, 9'd210, 9'd150}) begin
      errors++; $display("[TB] FAIL reset_carB: got %h expected %h", carB, {9'd330, 9'd270, 9'd210, 9'd150});
    end
    checks++;
    if (tick !== 1'b0 || wrap !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_pulses: got tick=%b wrap=%b expected 0 0", tick, wrap);
    end
    reset_in = 1'b1;
    step();
    checks++;
    if (carL !== pk10(0, 430, 300, 130) || tick !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_hold: got carL=%h tick=%b expected %h 0", carL, tick, pk10(0, 430, 300, 130));
    end
  endtask

  task automatic test_first_tick();
    run = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (tick !== 1'b0 || carL !== pk10(0, 430, 300, 130)) begin
        errors++; $display("[TB] FAIL pre_tick_%0d: got tick=%b carL=%h expected 0 %h", k, tick, carL, pk10(0, 430, 300, 130));
      end
    end
    step();
    checks++;
    if (tick !== 1'b1) begin
      errors++; $display("[TB] FAIL first_tick: got tick=%b expected 1", tick);
    end
    checks++;
    if (carL !== pk10(10, 415, 320, 105)) begin
      errors++; $display("[TB] FAIL first_move_carL: got %h expected %h", carL, pk10(10, 415, 320, 105));
    end
    checks++;
    if (carR !== pk10(70, 475, 380, 165) || wrap !== 4'b0) begin
      errors++; $display("[TB] FAIL first_move_carR: got %h wrap=%b expected %h 0000", carR, wrap, pk10(70, 475, 380, 165));
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit off;
    bit anyOff;
    logic [3:0] expWrap;
    anyOff = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      next_tick(cyc, off);
      anyOff |= off;
      checks++;
      if (cyc !== 4) begin
        errors++; $display("[TB] FAIL tick_period_%0d: got %0d cycles expected 4", k, cyc);
      end
      expWrap = (k == 6) ? 4'b1000 : (k == 15) ? 4'b0100 : 4'b0000;
      checks++;
      if (wrap !== expWrap) begin
        errors++; $display("[TB] FAIL wrap_tick_%0d: got %b expected %b", k, wrap, expWrap);
      end
      if (k == 5) begin
        checks++;
        if (carL[39:30] !== 10'd5) begin
          errors++; $display("[TB] FAIL lane3_at5: got %0d expected 5", carL[39:30]);
        end
      end
      if (k == 6) begin
        checks++;
        if (carL[39:30] !== 10'd580 || carR[39:30] !== 10'd640) begin
          errors++; $display("[TB] FAIL lane3_wrap: got L=%0d R=%0d expected 580 640", carL[39:30], carR[39:30]);
        end
      end
      if (k == 14) begin
        checks++;
        if (carL[29:20] !== 10'd580) begin
          errors++; $display("[TB] FAIL lane2_at580: got %0d expected 580", carL[29:20]);
        end
      end
    end
    checks++;
    if (carL !== pk10(150, 205, 0, 355)) begin
      errors++; $display("[TB] FAIL after_15_ticks: got %h expected %h", carL, pk10(150, 205, 0, 355));
    end
    checks++;
    if (anyOff !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_off_tick: got %b expected 0", anyOff);
    end
  endtask

  task automatic test_level();
    int cyc;
    bit off;
    step();
    level = 3'd5;
    step();
    checks++;
    if (carL !== pk10(150, 205, 0, 355) || tick !== 1'b0) begin
      errors++; $display("[TB] FAIL level_hold: got carL=%h tick=%b expected %h 0", carL, tick, pk10(150, 205, 0, 355));
    end
    next_tick(cyc, off);
    checks++;
    if (cyc !== 2) begin
      errors++; $display("[TB] FAIL level_tick_latency: got %0d expected 2", cyc);
    end
    checks++;
    if (carL !== pk10(190, 160, 50, 300)) begin
      errors++; $display("[TB] FAIL level5_move: got %h expected %h", carL, pk10(190, 160, 50, 300));
    end
  endtask

  task automatic test_freeze();
    int cyc;
    bit off;
    bit bad;
    bad = 1'b0;
    step();
    freeze = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick !== 1'b0 || wrap !== 4'b0 || carL !== pk10(190, 160, 50, 300) || carR !== pk10(250, 220, 110, 360))
        bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("[TB] FAIL freeze_hold: got disturbance=%b expected 0", bad);
    end
    freeze = 1'b0;
    next_tick(cyc, off);
    checks++;
    if (cyc !== 4) begin
      errors++; $display("[TB] FAIL freeze_resume_latency: got %0d expected 4", cyc);
    end
    checks++;
    if (carL !== pk10(230, 115, 100, 245)) begin
      errors++; $display("[TB] FAIL freeze_resume_move: got %h expected %h", carL, pk10(230, 115, 100, 245));
    end
  endtask

  task automatic test_run_drop();
    int cyc;
    bit off;
    step();
    run = 1'b0;
    step();
    checks++;
    if (carL !== pk10(0, 430, 300, 130) || carR !== pk10(60, 490, 360, 190) || tick !== 1'b0) begin
      errors++; $display("[TB] FAIL run_drop_restore: got carL=%h carR=%h tick=%b", carL, carR, tick);
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (tick !== 1'b0 || carL !== pk10(0, 430, 300, 130)) begin
      errors++; $display("[TB] FAIL idle_no_tick: got tick=%b carL=%h", tick, carL);
    end
    run = 1'b1;
    next_tick(cyc, off);
    checks++;
    if (cyc !== 5 || carL !== pk10(40, 385, 350, 75)) begin
      errors++; $display("[TB] FAIL rerun_tick: got cyc=%0d carL=%h expected 5 %h", cyc, carL, pk10(40, 385, 350, 75));
    end
    step();
    freeze = 1'b1;
    step();
    run = 1'b0;
    step();
    checks++;
    if (carL !== pk10(0, 430, 300, 130) || tick !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_drop_restore: got carL=%h tick=%b", carL, tick);
    end
    freeze = 1'b0;
    run = 1'b1;
    next_tick(cyc, off);
    checks++;
    if (cyc !== 5 || carL !== pk10(40, 385, 350, 75)) begin
      errors++; $display("[TB] FAIL pause_drop_counter: got cyc=%0d carL=%h expected 5 %h", cyc, carL, pk10(40, 385, 350, 75));
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit off;
    step();
    reset_in = 1'b0;
    step();
    checks++;
    if (carL !== pk10(0, 430, 300, 130) || tick !== 1'b0 || wrap !== 4'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got carL=%h tick=%b wrap=%b", carL, tick, wrap);
    end
    reset_in = 1'b1;
    next_tick(cyc, off);
    checks++;
    if (cyc !== 5 || carL !== pk10(40, 385, 350, 75)) begin
      errors++; $display("[TB] FAIL post_reset_tick: got cyc=%0d carL=%h expected 5 %h", cyc, carL, pk10(40, 385, 350, 75));
    end
    reset_in = 1'b0;
    #3;
    reset_in = 1'b1;
    step();
    checks++;
    if (carL !== pk10(40, 385, 350, 75)) begin
      errors++; $display("[TB] FAIL reset_glitch_hold: got %h expected %h", carL, pk10(40, 385, 350, 75));
    end
    next_tick(cyc, off);
    checks++;
    if (cyc !== 3 || carL !== pk10(80, 340, 400, 20)) begin
      errors++; $display("[TB] FAIL reset_glitch_tick: got cyc=%0d carL=%h expected 3 %h", cyc, carL, pk10(80, 340, 400, 20));
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_wrap();
    test_level();
    test_freeze();
    test_run_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
